// File: rtl/method_call_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : method_call_arbiter
// Purpose  : Shares one compiled-method call port (req / busy / return) among
//            NUM_CLI requesters. Arbitration is round-robin and only one call
//            is in flight at a time. The FSM runs the req-pulse / busy-rise /
//            busy-fall handshake, captures the return value and reports
//            completion or watchdog timeout to the owning client.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1        system clock, rising edge
//   reset          in   1        asynchronous reset, active low
//   cli_req        in   NUM_CLI  level request per client
//   cli_grant      out  NUM_CLI  one-hot owner of the method (ISSUE..COMPLETE)
//   cli_done       out  NUM_CLI  one-cycle end-of-call pulse to the owner
//   cli_err        out  NUM_CLI  with cli_done when the call timed out
//   cli_ret        out  RET_W    return value of the last successful call
//   method_req     out  1        one-cycle call request to the method
//   method_busy    in   1        method busy flag
//   method_return  in   RET_W    method return value
//   active         out  1        high whenever the FSM is not IDLE
// Parameter constraints: 2 <= NUM_CLI <= 8, 2**CNT_W > TIMEOUT.
// ============================================================================
module method_call_arbiter #(
  parameter int NUM_CLI = 4,
  parameter int RET_W   = 32,
  parameter int TIMEOUT = 10000,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CLI-1:0] cli_req,
  output logic [NUM_CLI-1:0] cli_grant,
  output logic [NUM_CLI-1:0] cli_done,
  output logic [NUM_CLI-1:0] cli_err,
  output logic [RET_W-1:0]   cli_ret,
  output logic               method_req,
  input  logic               method_busy,
  input  logic [RET_W-1:0]   method_return,
  output logic               active
);

  localparam int               IDX_W   = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_CLI - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_COMPLETE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic               err_q, err_d;
  logic [NUM_CLI-1:0] grant_q, grant_d;
  logic [RET_W-1:0]   ret_q, ret_d;

  // --------------------------------------------------------------------------
  // Round-robin pick: prefer the lowest requester above the last grant; if
  // there is none, wrap around and take the lowest requester overall.
  // --------------------------------------------------------------------------
  logic [NUM_CLI-1:0] above_mask;
  logic [NUM_CLI-1:0] req_hi;
  logic [NUM_CLI-1:0] pick_src;
  logic [IDX_W-1:0]   pick_idx;

  always_comb begin
    above_mask = '0;
    for (int i = 0; i < NUM_CLI; i++) begin
      above_mask[i] = (IDX_W'(i) > last_q);
    end
    req_hi   = cli_req & above_mask;
    pick_src = (|req_hi) ? req_hi : cli_req;
    pick_idx = '0;
    // Descending scan so the lowest set bit is the one that sticks.
    for (int i = NUM_CLI - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= IDX_TOP;   // client 0 wins the first arbitration
      wd_q    <= '0;
      err_q   <= 1'b0;
      grant_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      ret_q   <= ret_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wd_d    = wd_q;
    err_d   = err_q;
    grant_d = grant_q;
    ret_d   = ret_q;

    case (state_q)
      S_IDLE: begin
        // A busy callee is owned by someone else; do not start a call.
        if ((cli_req != '0) && !method_busy) begin
          idx_d   = pick_idx;
          grant_d = NUM_CLI'(1) << pick_idx;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT_START;
      end

      S_WAIT_START: begin
        // A low busy here is never a completion; only a rise moves us on.
        if (method_busy) begin
          wd_d    = '0;
          state_d = S_WAIT_DONE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!method_busy) begin
          ret_d   = method_return;
          state_d = S_COMPLETE;
        end else if (wd_q == WD_LAST) begin
          // Timed out: the previous return value is kept.
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end

      S_COMPLETE: begin
        last_d  = idx_q;
        grant_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs are decoded from registered state so reset clears them at once.
  // grant_q is the one-hot owner for the whole call, so it doubles as the
  // per-client mask for the done/err pulses.
  // --------------------------------------------------------------------------
  assign cli_grant  = grant_q;
  assign cli_done   = (state_q == S_COMPLETE) ? grant_q : '0;
  assign cli_err    = ((state_q == S_COMPLETE) && err_q) ? grant_q : '0;
  assign cli_ret    = ret_q;
  assign method_req = (state_q == S_ISSUE);
  assign active     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_method_call_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_method_call_arbiter
// Purpose  : Self-checking bench for method_call_arbiter. A behavioural
//            method model answers each method_req; expected completions are
//            queued as stimulus is driven and checked when cli_done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_method_call_arbiter;

  localparam int NC = 4;
  localparam int RW = 32;
  localparam int TO = 20;
  localparam int CW = 16;

  localparam int M_NORMAL  = 0;   // busy rises next cycle, falls after m_hold
  localparam int M_NO_RISE = 1;   // busy never rises
  localparam int M_NO_FALL = 2;   // busy rises and stays up for m_hold cycles

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] cli_req;
  logic [NC-1:0] cli_grant;
  logic [NC-1:0] cli_done;
  logic [NC-1:0] cli_err;
  logic [RW-1:0] cli_ret;
  logic          method_req;
  logic          method_busy;
  logic [RW-1:0] method_return;
  logic          active;

  int m_mode = M_NORMAL;
  int m_hold = 3;
  int m_calls;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            idx;
    bit            err;
    logic [RW-1:0] ret;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [NC-1:0] mon_prev;
  logic [63:0]   mon_oh;
  int            pcall = 0;
  logic [RW-1:0] last_ret = '0;

  method_call_arbiter #(
    .NUM_CLI (NC),
    .RET_W   (RW),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cli_req       (cli_req),
    .cli_grant     (cli_grant),
    .cli_done      (cli_done),
    .cli_err       (cli_err),
    .cli_ret       (cli_ret),
    .method_req    (method_req),
    .method_busy   (method_busy),
    .method_return (method_return),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ok(input int idx);
    exp_t e;
    e.idx = idx;
    e.err = 1'b0;
    e.ret = 32'd1 + RW'(pcall);
    pcall++;
    last_ret = e.ret;
    sb.push_back(e);
  endtask

  task automatic push_to(input int idx);
    exp_t e;
    e.idx = idx;
    e.err = 1'b1;
    e.ret = last_ret;
    sb.push_back(e);
  endtask

  task automatic wait_method_req(input int max, output int waited);
    waited = 0;
    while (method_req !== 1'b1 && waited < max) begin
      cyc(1);
      waited++;
    end
    check("method_req_seen", method_req, 1);
  endtask

  task automatic wait_dones(input int cnt, input int max, input string tag);
    int k = 0;
    int n = 0;
    while (k < cnt && n < max) begin
      cyc(1);
      n++;
      if (cli_done != '0) k++;
    end
    check(tag, k, cnt);
  endtask

  // Method model: answers a method_req seen on a falling edge.
  initial begin
    method_busy   = 1'b0;
    method_return = '0;
    m_calls       = 0;
    forever begin
      @(negedge clk);
      if (method_req === 1'b1) begin
        if (m_mode == M_NORMAL) begin
          @(negedge clk);
          method_busy = 1'b1;
          repeat (m_hold) @(negedge clk);
          method_busy   = 1'b0;
          method_return = 32'd1 + RW'(m_calls);
          m_calls++;
        end else if (m_mode == M_NO_FALL) begin
          @(negedge clk);
          method_busy = 1'b1;
          repeat (m_hold) @(negedge clk);
          method_busy = 1'b0;
        end
      end
    end
  end

  // Completion monitor / scoreboard consumer.
  initial begin
    mon_prev = '0;
    forever begin
      @(negedge clk);
      if (mon_prev != '0) check("done_one_cycle", cli_done, 0);
      if (active === 1'b1) check("grant_onehot", $onehot(cli_grant), 1);
      if (cli_done != '0) begin
        if (sb.size() == 0) begin
          check("done_unexpected", cli_done, 0);
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = 64'd1 << mon_e.idx;
          check("done_client", cli_done, mon_oh);
          check("done_grant", cli_grant, mon_oh);
          check("done_err", cli_err, mon_e.err ? mon_oh : 64'd0);
          check("done_ret", cli_ret, mon_e.ret);
        end
      end
      mon_prev = cli_done;
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int w;
    cli_req = '0;
    cyc(3);

    // Reset state
    check("rst_grant", cli_grant, 0);
    check("rst_done", cli_done, 0);
    check("rst_err", cli_err, 0);
    check("rst_ret", cli_ret, 0);
    check("rst_method_req", method_req, 0);
    check("rst_active", active, 0);
    reset = 1'b1;
    cyc(2);
    check("idle_active", active, 0);

    // Single call; client drops its request mid-call
    m_mode = M_NORMAL;
    m_hold = 3;
    push_ok(0);
    cli_req = 4'b0001;
    cyc(1);
    check("sc_method_req", method_req, 1);
    check("sc_grant", cli_grant, 4'b0001);
    check("sc_active", active, 1);
    cli_req = '0;
    cyc(1);
    check("sc_req_pulse", method_req, 0);
    n = 2;
    while (cli_done == '0 && n < 60) begin
      cyc(1);
      n++;
    end
    check("sc_done_cycle", n, 6);
    cyc(1);
    check("sc_ret_hold", cli_ret, 1);
    check("sc_idle", active, 0);

    // Contention, pointer starts after client 0
    m_hold = 2;
    push_ok(1); push_ok(3); push_ok(0); push_ok(1); push_ok(3); push_ok(0);
    cli_req = 4'b1011;
    wait_dones(6, 400, "ct_all_done");
    cli_req = '0;
    cyc(3);
    check("ct_idle", active, 0);
    check("ct_sb_empty", sb.size(), 0);

    // Round-robin wrap: serve 3, then 1001 gives 0 then 3
    push_ok(3);
    cli_req = 4'b1000;
    wait_dones(1, 60, "rr_serve3");
    cli_req = '0;
    cyc(2);
    push_ok(0); push_ok(3);
    cli_req = 4'b1001;
    wait_dones(2, 120, "rr_wrap");
    cli_req = '0;
    cyc(2);

    // Single client held high: back-to-back service at minimum spacing
    m_hold = 1;
    push_ok(2); push_ok(2);
    cli_req = 4'b0100;
    wait_dones(1, 60, "b2b_first");
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (cli_done == '0 && n < 60);
    cli_req = '0;
    check("b2b_gap", n, 5);
    cyc(2);

    // Start timeout: busy never rises
    m_mode = M_NO_RISE;
    push_to(1);
    cli_req = 4'b0010;
    wait_method_req(20, w);
    cli_req = '0;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (cli_done == '0 && n < 100);
    check("st_done_cycle", n, 21);
    check("st_err", cli_err, 4'b0010);
    cyc(1);
    check("st_ret_keep", cli_ret, last_ret);

    // Next request after a timeout is still served
    m_mode = M_NORMAL;
    m_hold = 2;
    push_ok(0);
    cli_req = 4'b0001;
    wait_dones(1, 60, "st_recover");
    cli_req = '0;
    cyc(2);

    // Done timeout, then callee-busy gating with the request still pending
    m_mode = M_NO_FALL;
    m_hold = 30;
    push_to(2);
    cli_req = 4'b0100;
    wait_method_req(20, w);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (cli_done == '0 && n < 100);
    check("dt_done_cycle", n, 22);
    m_mode = M_NORMAL;
    m_hold = 2;
    push_ok(2);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("gate_no_req", method_req, 0);
    end
    wait_method_req(10, w);
    check("gate_release_cycle", w, 2);
    cli_req = '0;
    wait_dones(1, 60, "gate_call_done");
    cyc(2);

    // Asynchronous reset in the middle of WAIT_DONE
    m_mode = M_NO_FALL;
    m_hold = 30;
    cli_req = 4'b1111;
    wait_method_req(20, w);
    check("ar_grant_pre", cli_grant, 4'b1000);
    cyc(4);
    #2;
    reset = 1'b0;
    #1;
    check("ar_grant", cli_grant, 0);
    check("ar_active", active, 0);
    check("ar_method_req", method_req, 0);
    check("ar_done", cli_done, 0);
    check("ar_err", cli_err, 0);
    check("ar_ret", cli_ret, 0);
    last_ret = '0;
    m_mode = M_NORMAL;
    m_hold = 2;
    cyc(2);
    reset = 1'b1;
    push_ok(0);
    wait_method_req(60, w);
    check("ar_first_grant", cli_grant, 4'b0001);
    cli_req = '0;
    wait_dones(1, 60, "ar_call_done");

    cyc(3);
    check("final_sb_empty", sb.size(), 0);
    check("final_idle", active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/method_call_arbiter.md
Name: method_call_arbiter

Overview:
- Shares one compiled-method call port (`<method>_req` / `<method>_busy` / `<method>_return`) among NUM_CLI requesters.
- Sits between several callers and a single method instance inside a generated module.
- Arbitration is round-robin; one call is in flight at a time.
- Sequences the req-pulse / busy-rise / busy-fall handshake, captures the return value and reports completion or watchdog timeout per client.

Parameters:
- NUM_CLI, 4, number of requesting clients (2..8)
- RET_W, 32, width of method return value
- TIMEOUT, 10000, cycles allowed in each wait state before a call is aborted
- CNT_W, 16, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cli_req  in  NUM_CLI  level request per client; bit i high = client i wants a call
- cli_grant  out  NUM_CLI  one-hot; marks the client currently owning the method
- cli_done  out  NUM_CLI  one-cycle pulse to the owning client at call end
- cli_err  out  NUM_CLI  one-cycle pulse, coincident with cli_done, if the call timed out
- cli_ret  out  RET_W  return value of the last completed call; valid when any cli_done bit is high
- method_req  out  1  call request to the method
- method_busy  in  1  method busy flag
- method_return  in  RET_W  method return value
- active  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, state IDLE, last-grant pointer = NUM_CLI-1 (so client 0 wins first), watchdog = 0. Reset mid-call abandons the call with no done/err pulse.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, COMPLETE.
- IDLE:
  - Requires cli_req != 0 and method_busy == 0.
  - Select the first set bit searching upward from last_grant+1 with wrap-around.
  - Register the index and drive cli_grant one-hot next cycle; go to ISSUE.
  - If method_busy is high, stay in IDLE (callee owned elsewhere).
- ISSUE: method_req = 1 for exactly this one cycle; clear watchdog; go to WAIT_START.
- WAIT_START:
  - method_req = 0.
  - method_busy == 1: clear watchdog, go to WAIT_DONE.
  - Otherwise increment watchdog; when watchdog == TIMEOUT-1, set err flag and go to COMPLETE.
- WAIT_DONE:
  - method_busy == 0: latch method_return into cli_ret, go to COMPLETE.
  - Otherwise increment watchdog; when watchdog == TIMEOUT-1, set err flag and go to COMPLETE. cli_ret is left unchanged on timeout.
- COMPLETE:
  - cli_done[idx] = 1 for one cycle; cli_err[idx] = err flag.
  - last_grant = idx; clear cli_grant and err flag; go to IDLE.
- Latency: cli_req seen in IDLE at cycle 0 gives method_req at cycle 1. If busy rises at cycle 2 and falls at cycle k, cli_done is at cycle k+1. Minimum idle-to-idle is 5 cycles.
- Fairness:
  - A client holding cli_req high after its done is served again only after all other pending clients.
  - A single client holding req continuously is re-served back-to-back.
- A client dropping cli_req mid-call is ignored: the call completes and cli_done still pulses.
- Simultaneous requests are resolved by the round-robin pointer only; there is no fixed priority.
- method_busy glitching low during WAIT_START is not a completion; only a fall after a rise ends the call.
- cli_ret holds its value until the next successful completion.

Test Plan:
- Single call: client 0 requests; model busy high 3 cycles after method_req, return 32'h1.
  - Expect method_req pulse at cycle 1, cli_done[0] one cycle after busy falls, cli_ret=1, cli_err=0.
- Contention: cli_req=4'b1011 held.
  - Grant order 0,1,3,0,1,3; each cli_grant one-hot; no overlap between calls; each done pulse is one cycle.
- Round-robin wrap: after client 3 is served, cli_req=4'b1001 → client 0 granted next, then 3.
- Start timeout: TIMEOUT=20, model never raises busy.
  - cli_done[i] and cli_err[i] pulse together 20 cycles after the WAIT_START entry; cli_ret unchanged; next request still served.
- Done timeout: busy stays high forever → cli_err after 20 cycles in WAIT_DONE. Callee-busy gating: busy high while idle with req pending → method_req stays 0 until busy is low.
- Async reset: assert reset low mid-WAIT_DONE, between clock edges.
  - Outputs 0 immediately; no done pulse after release.
  - First post-reset grant goes to client 0 when all request.
